// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads a 1-cycle-latency BRAM, buffers words in a
// 2-entry queue toward decode. Define IFETCH_PERF_EN to add fetch/stall performance counters.
module ifetch_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  load_valid_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  output logic                  load_ready_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_data_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rd_n_o,
  output logic                  mem_wr_n_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched_o,
  output logic [31:0]           perf_stall_o
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  epoch_q, epoch_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_epoch_q, inflight_epoch_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]            count_q, count_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] q_data_q [2];
  logic [ADDR_WIDTH-1:0] q_pc_q [2];

  logic       issue, land, deq, flush;
  logic [2:0] occ;

  // Words buffered plus the one possibly on the BRAM output bus.
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q};
  assign flush = redirect_valid_i | stop_i;

  assign busy_o       = (state_q != StIdle);
  assign mem_wdata_o  = load_data_i;
  assign instr_data_o = q_data_q[rd_ptr_q];
  assign instr_pc_o   = q_pc_q[rd_ptr_q];

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    epoch_d          = epoch_q;
    issue            = 1'b0;
    load_ready_o     = 1'b0;
    mem_wr_n_o       = 1'b1;
    mem_addr_o       = pc_q;
    instr_valid_o    = (count_q != 2'd0) && !redirect_valid_i;
    deq              = instr_valid_o && instr_ready_i;

    unique case (state_q)
      StIdle: begin
        load_ready_o = rst_ni && !start_i;
        if (load_valid_i && load_ready_o) begin
          mem_wr_n_o = 1'b0;
          mem_addr_o = load_addr_i;
        end
        if (start_i) state_d = StRun;
      end
      StRun: begin
        issue = !redirect_valid_i && !stop_i && (occ < (3'd2 + {2'b00, deq}));
        if (stop_i) state_d = StDrain;
      end
      StDrain: begin
        if (!inflight_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    mem_rd_n_o = !issue;
    if (issue) pc_d = pc_q + 1'b1;
    if (redirect_valid_i) begin
      pc_d    = redirect_pc_i;
      epoch_d = ~epoch_q;
    end

    inflight_d       = issue;
    inflight_pc_d    = pc_q;
    inflight_epoch_d = epoch_q;

    // A returning word is kept only if no flush coincides and its epoch is current.
    land = inflight_q && (inflight_epoch_q == epoch_q) && (state_q == StRun) && !flush;

    rd_ptr_d = rd_ptr_q ^ deq;
    wr_ptr_d = wr_ptr_q ^ land;
    count_d  = count_q + {1'b0, land} - {1'b0, deq};
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= StIdle;
      pc_q             <= RESET_PC;
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      inflight_pc_q    <= '0;
      count_q          <= 2'd0;
      rd_ptr_q         <= 1'b0;
      wr_ptr_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      epoch_q          <= epoch_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      inflight_pc_q    <= inflight_pc_d;
      count_q          <= count_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        q_data_q[i] <= '0;
        q_pc_q[i]   <= '0;
      end
    end else if (land) begin
      q_data_q[wr_ptr_q] <= mem_rdata_i;
      q_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else if ((state_q == StIdle) && start_i) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (deq && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
      if ((state_q == StRun) && !instr_valid_o && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed-vector bench for ifetch_ctrl with a behavioural 1-cycle BRAM; a second instance
// exercises PC wrap from a non-zero reset PC.
module tb_ifetch_ctrl;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, stop = 1'b0, redirect_valid = 1'b0, load_valid = 1'b0;
  logic          instr_ready = 1'b0;
  logic [AW-1:0] redirect_pc = '0, load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready, instr_valid, mem_rd_n, mem_wr_n, busy;
  logic [DW-1:0] instr_data, mem_wdata, mem_rdata;
  logic [AW-1:0] instr_pc, mem_addr;
`ifdef IFETCH_PERF_EN
  logic [31:0]   perf_fetched, perf_stall, perf_fetched2, perf_stall2;
`endif

  ifetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(10'h000)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .load_valid_i(load_valid), .load_addr_i(load_addr), .load_data_i(load_data),
    .load_ready_o(load_ready), .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_data_o(instr_data), .instr_pc_o(instr_pc), .mem_addr_o(mem_addr),
    .mem_rd_n_o(mem_rd_n), .mem_wr_n_o(mem_wr_n), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
`ifdef IFETCH_PERF_EN
    , .perf_fetched_o(perf_fetched), .perf_stall_o(perf_stall)
`endif
  );

  // BRAM model: unwritten words read back as 0xDEAD0000 | address.
  logic [DW-1:0] mem [1024];
  logic [1023:0] written = '0;
  always @(posedge clk) begin
    if (!mem_wr_n) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    if (!mem_rd_n) mem_rdata <= written[mem_addr] ? mem[mem_addr] : (32'hDEAD0000 | {22'h0, mem_addr});
  end

  logic          start2 = 1'b0;
  logic          load_ready2, instr_valid2, mem_rd_n2, mem_wr_n2, busy2;
  logic [DW-1:0] instr_data2, mem_wdata2, mem_rdata2;
  logic [AW-1:0] instr_pc2, mem_addr2;

  ifetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(10'h3FE)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .stop_i(1'b0),
    .redirect_valid_i(1'b0), .redirect_pc_i('0),
    .load_valid_i(1'b0), .load_addr_i('0), .load_data_i('0),
    .load_ready_o(load_ready2), .instr_valid_o(instr_valid2), .instr_ready_i(1'b1),
    .instr_data_o(instr_data2), .instr_pc_o(instr_pc2), .mem_addr_o(mem_addr2),
    .mem_rd_n_o(mem_rd_n2), .mem_wr_n_o(mem_wr_n2), .mem_wdata_o(mem_wdata2),
    .mem_rdata_i(mem_rdata2), .busy_o(busy2)
`ifdef IFETCH_PERF_EN
    , .perf_fetched_o(perf_fetched2), .perf_stall_o(perf_stall2)
`endif
  );

  always @(posedge clk) begin
    if (!mem_rd_n2) mem_rdata2 <= 32'h5A5A0000 ^ {22'h0, mem_addr2};
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // fin = {start, stop, redirect_valid, load_valid, instr_ready}
  // fexp = {instr_valid, mem_rd_n, mem_wr_n, busy, load_ready, check_instr}
  typedef struct {
    logic [4:0]    fin;
    logic [AW-1:0] rpc;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    logic [5:0]    fexp;
    logic [AW-1:0] epc;
    logic [DW-1:0] edat;
    logic [AW-1:0] eaddr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [4:0] fin, input logic [AW-1:0] rpc,
                              input logic [AW-1:0] la, input logic [DW-1:0] ld,
                              input logic [5:0] fexp, input logic [AW-1:0] epc,
                              input logic [DW-1:0] edat, input logic [AW-1:0] eaddr);
    vec_t v;
    v.fin = fin; v.rpc = rpc; v.la = la; v.ld = ld;
    v.fexp = fexp; v.epc = epc; v.edat = edat; v.eaddr = eaddr;
    return v;
  endfunction

  logic          ev, erd, ewr, eb, elr, cv;
  logic [AW-1:0] wrap_pc [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Load A0..A3, start, backpressure 5 cycles, redirect to 0x200, stop + load, restart.
    tv.push_back(mk(5'b00000, 10'h0,   10'h0, 32'h0,  6'b011011, 10'h0,   32'h0,        10'h0));
    tv.push_back(mk(5'b00010, 10'h0,   10'h0, 32'hA0, 6'b010011, 10'h0,   32'h0,        10'h0));
    tv.push_back(mk(5'b00010, 10'h0,   10'h1, 32'hA1, 6'b010011, 10'h0,   32'h0,        10'h1));
    tv.push_back(mk(5'b00010, 10'h0,   10'h2, 32'hA2, 6'b010011, 10'h0,   32'h0,        10'h2));
    tv.push_back(mk(5'b00010, 10'h0,   10'h3, 32'hA3, 6'b010011, 10'h0,   32'h0,        10'h3));
    tv.push_back(mk(5'b10011, 10'h0,   10'h4, 32'hBB, 6'b011001, 10'h0,   32'h0,        10'h0));
    tv.push_back(mk(5'b00000, 10'h0,   10'h0, 32'h0,  6'b001101, 10'h0,   32'h0,        10'h0));
    tv.push_back(mk(5'b00000, 10'h0,   10'h0, 32'h0,  6'b001101, 10'h0,   32'h0,        10'h1));
    for (int k = 0; k < 5; k++) begin
      tv.push_back(mk(5'b00000, 10'h0, 10'h0, 32'h0,  6'b111101, 10'h0,   32'hA0,       10'h0));
    end
    tv.push_back(mk(5'b00001, 10'h0,   10'h0, 32'h0,  6'b101101, 10'h0,   32'hA0,       10'h2));
    tv.push_back(mk(5'b00001, 10'h0,   10'h0, 32'h0,  6'b101101, 10'h1,   32'hA1,       10'h3));
    tv.push_back(mk(5'b00001, 10'h0,   10'h0, 32'h0,  6'b101101, 10'h2,   32'hA2,       10'h4));
    tv.push_back(mk(5'b00001, 10'h0,   10'h0, 32'h0,  6'b101101, 10'h3,   32'hA3,       10'h5));
    tv.push_back(mk(5'b00101, 10'h200, 10'h0, 32'h0,  6'b011101, 10'h0,   32'h0,        10'h0));
    tv.push_back(mk(5'b00001, 10'h0,   10'h0, 32'h0,  6'b001101, 10'h0,   32'h0,        10'h200));
    tv.push_back(mk(5'b00001, 10'h0,   10'h0, 32'h0,  6'b001101, 10'h0,   32'h0,        10'h201));
    tv.push_back(mk(5'b00001, 10'h0,   10'h0, 32'h0,  6'b101101, 10'h200, 32'hDEAD0200, 10'h202));
    tv.push_back(mk(5'b00001, 10'h0,   10'h0, 32'h0,  6'b101101, 10'h201, 32'hDEAD0201, 10'h203));
    tv.push_back(mk(5'b01011, 10'h0,   10'h5, 32'h55, 6'b011100, 10'h0,   32'h0,        10'h0));
    tv.push_back(mk(5'b00011, 10'h0,   10'h5, 32'h55, 6'b011101, 10'h0,   32'h0,        10'h0));
    tv.push_back(mk(5'b00011, 10'h0,   10'h5, 32'h55, 6'b010011, 10'h0,   32'h0,        10'h5));
    tv.push_back(mk(5'b00001, 10'h0,   10'h0, 32'h0,  6'b011011, 10'h0,   32'h0,        10'h0));
    tv.push_back(mk(5'b00101, 10'h5,   10'h0, 32'h0,  6'b011011, 10'h0,   32'h0,        10'h0));
    tv.push_back(mk(5'b10001, 10'h0,   10'h0, 32'h0,  6'b011001, 10'h0,   32'h0,        10'h0));
    tv.push_back(mk(5'b00001, 10'h0,   10'h0, 32'h0,  6'b001101, 10'h0,   32'h0,        10'h5));
    tv.push_back(mk(5'b00001, 10'h0,   10'h0, 32'h0,  6'b001101, 10'h0,   32'h0,        10'h6));
    tv.push_back(mk(5'b00001, 10'h0,   10'h0, 32'h0,  6'b101101, 10'h5,   32'h55,       10'h7));
    tv.push_back(mk(5'b00001, 10'h0,   10'h0, 32'h0,  6'b101101, 10'h6,   32'hDEAD0006, 10'h8));

    wrap_pc[0] = 10'h3FE; wrap_pc[1] = 10'h3FF; wrap_pc[2] = 10'h000; wrap_pc[3] = 10'h001;

    // Reset state, sampled while reset is held.
    @(posedge clk); #1;
    chk("reset mem_rd_n", 32'(mem_rd_n), 32'd1);
    chk("reset mem_wr_n", 32'(mem_wr_n), 32'd1);
    chk("reset instr_valid", 32'(instr_valid), 32'd0);
    chk("reset load_ready", 32'(load_ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      {start, stop, redirect_valid, load_valid, instr_ready} = tv[i].fin;
      redirect_pc = tv[i].rpc;
      load_addr   = tv[i].la;
      load_data   = tv[i].ld;
      #1;
      {ev, erd, ewr, eb, elr, cv} = tv[i].fexp;
      if (cv) begin
        chk($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(ev));
        if (ev) begin
          chk($sformatf("v%0d instr_pc", i), 32'(instr_pc), 32'(tv[i].epc));
          chk($sformatf("v%0d instr_data", i), instr_data, tv[i].edat);
        end
      end
      chk($sformatf("v%0d mem_rd_n", i), 32'(mem_rd_n), 32'(erd));
      chk($sformatf("v%0d mem_wr_n", i), 32'(mem_wr_n), 32'(ewr));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(eb));
      chk($sformatf("v%0d load_ready", i), 32'(load_ready), 32'(elr));
      if (!erd || !ewr) chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(tv[i].eaddr));
    end

    // Asynchronous reset mid-stream, then restart from RESET_PC.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async rst mem_rd_n", 32'(mem_rd_n), 32'd1);
    chk("async rst instr_valid", 32'(instr_valid), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
`ifdef IFETCH_PERF_EN
    chk("async rst perf_fetched", perf_fetched, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    {start, stop, redirect_valid, load_valid, instr_ready} = 5'b00001;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("restart c1 mem_rd_n", 32'(mem_rd_n), 32'd0);
    chk("restart c1 mem_addr", 32'(mem_addr), 32'h000);
    @(negedge clk); #1;
    chk("restart c2 instr_valid", 32'(instr_valid), 32'd0);
    @(negedge clk); #1;
    chk("restart c3 instr_valid", 32'(instr_valid), 32'd1);
    chk("restart c3 instr_pc", 32'(instr_pc), 32'h000);
    chk("restart c3 instr_data", instr_data, 32'hA0);
`ifdef IFETCH_PERF_EN
    chk("restart c3 perf_stall", perf_stall, 32'd2);
    chk("restart c3 perf_fetched", perf_fetched, 32'd0);
`endif
    @(negedge clk); #1;
    chk("restart c4 instr_pc", 32'(instr_pc), 32'h001);
    chk("restart c4 instr_data", instr_data, 32'hA1);

    // Non-zero RESET_PC wraps past the top of the address space.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      if (k >= 3) begin
        chk($sformatf("wrap c%0d instr_valid", k), 32'(instr_valid2), 32'd1);
        chk($sformatf("wrap c%0d instr_pc", k), 32'(instr_pc2), 32'(wrap_pc[k-3]));
        chk($sformatf("wrap c%0d instr_data", k), instr_data2,
            32'h5A5A0000 ^ {22'h0, wrap_pc[k-3]});
      end else begin
        chk($sformatf("wrap c%0d instr_valid", k), 32'(instr_valid2), 32'd0);
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
